shift_reg_univ: RTL and testbench
=================================

# shift_reg_univ

Parametrised universal shift register: the next generation of the team's single-bit D flip-flop with complementary output. It holds a WIDTH-bit word and supports hold, parallel load, logical shift, rotate, clear and an LFSR step mode. It also provides a complementary output, a serial output and a zero flag. It serves as the general storage, serialiser and pseudo-random source for datapath blocks.

## Interface
- WIDTH, 8, register width in bits; minimum 2.
- TAPS, 8'hB8, LFSR feedback tap mask, WIDTH bits; bit i set means q[i] feeds the XOR.
- SEED, 1, value loaded in LFSR mode when q is all-zero; must be non-zero.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- en  input  1  clock enable; 0 means hold all outputs.
- mode  input  3  operation select, see Operation.
- d  input  WIDTH  parallel load data.
- si  input  1  serial input for shift modes.
- q  output  WIDTH  registered state.
- qb  output  WIDTH  registered, always equal to ~q.
- so  output  1  registered; last bit shifted or rotated out.
- zero  output  1  registered; 1 when q == 0.

## Operation
- Priority per rising edge: rst, then en==0 (hold), then mode.
- Reset: q=0, qb=all ones, so=0, zero=1.
- mode 000 (hold): no change to any output.
- mode 001 (shift right): q <= {si, q[WIDTH-1:1]}; so <= q[0].
- mode 010 (shift left): q <= {q[WIDTH-2:0], si}; so <= q[WIDTH-1].
- mode 011 (load): q <= d; so unchanged.
- mode 100 (rotate right): q <= {q[0], q[WIDTH-1:1]}; so <= q[0]; si ignored.
- mode 101 (rotate left): q <= {q[WIDTH-2:0], q[WIDTH-1]}; so <= q[WIDTH-1]; si ignored.
- mode 110 (LFSR step, Fibonacci, shift left):
  - If q == 0: q <= SEED. This is lock-up escape.
  - Otherwise: q <= {q[WIDTH-2:0], ^(q & TAPS)}.
  - so <= q[WIDTH-1] in both cases.
- mode 111 (clear): q <= 0; so <= 0.
- Derived outputs:
  - qb and zero are computed from the next value of q and registered in the same edge, so they are never one cycle stale relative to q.
  - so is unchanged in hold and load modes.
- Width rules:
  - All shifts are single-bit per enabled edge.
  - No arithmetic carry; bits leaving the register are lost except the one captured in so.
- Outputs change only on a rising edge of clk; no combinational path from any input to any output.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on q/qb/so/zero after edge N.
- Next state always uses the q value present before the edge.
- Consecutive enabled shift edges shift one bit per cycle with no bubbles.
- rst asserted mid-sequence overrides en and mode on that edge. Operation resumes from the reset state on the first edge with rst=0.
- en=0 together with any mode leaves all outputs unchanged, including so and zero.
- Mode changes take effect on the edge where the new mode is sampled; there is no pipeline to flush.
- LFSR with q==0 takes exactly one edge to reach SEED. With the default TAPS the sequence is maximal length (255 states) and never reaches 0.

## Test plan
- Reset: d=8'hA5, mode=011, en=1, rst=1 for 2 edges -> q=8'h00, qb=8'hFF, so=0, zero=1.
- Load then shift right: load 8'hA5; next edge mode=001, si=1 -> q=8'hD2, qb=8'h2D, so=1, zero=0.
- Shift left and rotate left from 8'hA5:
  - Shift left, si=0 -> q=8'h4A, so=1.
  - Reload 8'hA5, rotate left -> q=8'h4B, so=1.
  - Reload 8'hA5, rotate right -> q=8'hD2, so=1.
- LFSR from zero: mode=110 from q=8'h00 -> successive q = 01, 02, 04, 08, 11.
  - Run 255 edges and check the value returns to 8'h01, never hitting 00.
- Enable and clear: q=8'h3C, en=0, mode=001 for 3 edges -> q stays 3C and so unchanged; then en=1, mode=111 -> q=00, so=0, zero=1.
- Reset mid-operation: shifting 8'hFF left with si=1, assert rst for one edge -> q=00, qb=FF on that edge. Deassert rst with mode=001, si=1 -> q=8'h80.

Source files
------------

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register: hold, load, shift, rotate, clear and LFSR step,
// with registered complement, serial-out and zero-flag outputs.
module shift_reg_univ #(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0]  SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             so,
    output logic             zero
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_ROL   = 3'b101,
        MODE_LFSR  = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qb_q, qb_d;
    logic             so_q, so_d;
    logic             zero_q, zero_d;
    logic             lfsr_fb;

    assign lfsr_fb = ^(q_q & TAPS);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
        q_d = q_q;
        so_d = so_q;
        if (en) begin
            unique case (mode_e'(mode))
                MODE_HOLD: ;
                MODE_SHR: begin
                    q_d  = {si, q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
                MODE_SHL: begin
                    q_d  = {q_q[WIDTH-2:0], si};
                    so_d = q_q[WIDTH-1];
                end
                MODE_LOAD: q_d = d;
                MODE_ROR: begin
                    q_d  = {q_q[0], q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    so_d = q_q[WIDTH-1];
                end
                MODE_LFSR: begin
                    // An all-zero register would lock the LFSR; escape to SEED in one step.
                    q_d  = (q_q == '0) ? SEED : {q_q[WIDTH-2:0], lfsr_fb};
                    so_d = q_q[WIDTH-1];
                end
                MODE_CLEAR: begin
                    q_d  = '0;
                    so_d = 1'b0;
                end
                default: ;
            endcase
        end
        // Derived from the next q so they register on the same edge as q itself.
        qb_d   = ~q_d;
        zero_d = (q_d == '0);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            q_q    <= '0;
            qb_q   <= '1;
            so_q   <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            q_q    <= q_d;
            qb_q   <= qb_d;
            so_q   <= so_d;
            zero_q <= zero_d;
        end
    end

    assign q    = q_q;
    assign qb   = qb_q;
    assign so   = so_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ: stimulus pushes hand-computed expectations,
// a monitor pops and compares one entry after every rising edge.
module tb_shift_reg_univ;

    localparam int W = 8;

    typedef enum logic [1:0] {CHK_NONE, CHK_Q, CHK_ALL, CHK_NZ} chk_e;

    typedef struct {
        chk_e         kind;
        logic [W-1:0] q;
        logic         so;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic [2:0]   mode = 3'b011;
    logic [W-1:0] d = 8'hA5;
    logic         si = 1'b0;
    logic [W-1:0] q, qb;
    logic         so, zero;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   stim_done = 1'b0;

    shift_reg_univ #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .si(si),
        .q(q), .qb(qb), .so(so), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one edge's inputs and queue what the outputs must be after it.
    task automatic step(input logic r, input logic e, input logic [2:0] m, input logic [W-1:0] dv,
                        input logic s, input chk_e k, input logic [W-1:0] eq, input logic eso,
                        input string name);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; mode = m; d = dv; si = s;
        x.kind = k; x.q = eq; x.so = eso; x.name = name;
        exp_q.push_back(x);
    endtask

    // Monitor: one queue entry per rising edge, sampled just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                case (x.kind)
                    CHK_Q, CHK_ALL: begin
                        check({x.name, ".q"}, q, x.q);
                        check({x.name, ".qb"}, qb, ~x.q);
                        check({x.name, ".zero"}, W'(zero), W'(x.q == '0));
                        if (x.kind == CHK_ALL) check({x.name, ".so"}, W'(so), W'(x.so));
                    end
                    CHK_NZ: begin
                        total++;
                        if (q == '0 || zero !== 1'b0) begin
                            bad++;
                            $display("FAIL %s: got q=%h zero=%b expected nonzero", x.name, q, zero);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held two edges while a load is requested.
        step(1, 1, 3'b011, 8'hA5, 0, CHK_ALL, 8'h00, 0, "reset1");
        step(1, 1, 3'b011, 8'hA5, 0, CHK_ALL, 8'h00, 0, "reset2");
        // Load, shift right with si=1.
        step(0, 1, 3'b011, 8'hA5, 0, CHK_ALL, 8'hA5, 0, "load_a5");
        step(0, 1, 3'b001, 8'h00, 1, CHK_ALL, 8'hD2, 1, "shr");
        // Shift left, rotate left, rotate right from A5.
        step(0, 1, 3'b011, 8'hA5, 0, CHK_ALL, 8'hA5, 1, "reload1");
        step(0, 1, 3'b010, 8'h00, 0, CHK_ALL, 8'h4A, 1, "shl");
        step(0, 1, 3'b011, 8'hA5, 0, CHK_ALL, 8'hA5, 1, "reload2");
        step(0, 1, 3'b101, 8'h00, 0, CHK_ALL, 8'h4B, 1, "rol");
        step(0, 1, 3'b011, 8'hA5, 0, CHK_ALL, 8'hA5, 1, "reload3");
        step(0, 1, 3'b100, 8'h00, 1, CHK_ALL, 8'hD2, 1, "ror");
        // Clear, then LFSR from zero.
        step(0, 1, 3'b111, 8'h00, 0, CHK_ALL, 8'h00, 0, "clear1");
        step(0, 1, 3'b110, 8'h00, 0, CHK_ALL, 8'h01, 0, "lfsr_seed");
        step(0, 1, 3'b110, 8'h00, 0, CHK_ALL, 8'h02, 0, "lfsr2");
        step(0, 1, 3'b110, 8'h00, 0, CHK_ALL, 8'h04, 0, "lfsr3");
        step(0, 1, 3'b110, 8'h00, 0, CHK_ALL, 8'h08, 0, "lfsr4");
        step(0, 1, 3'b110, 8'h00, 0, CHK_ALL, 8'h11, 0, "lfsr5");
        // 251 more steps completes the 255-state period back at 01 (predecessor 80 gives so=1).
        for (int i = 0; i < 250; i++)
            step(0, 1, 3'b110, 8'h00, 0, CHK_NZ, 8'h00, 0, "lfsr_nz");
        step(0, 1, 3'b110, 8'h00, 0, CHK_ALL, 8'h01, 1, "lfsr_wrap");
        // Enable low holds everything, including so.
        step(0, 1, 3'b011, 8'h3C, 0, CHK_ALL, 8'h3C, 1, "load_3c");
        for (int i = 0; i < 3; i++)
            step(0, 0, 3'b001, 8'h00, 0, CHK_ALL, 8'h3C, 1, "en_hold");
        step(0, 1, 3'b111, 8'h00, 0, CHK_ALL, 8'h00, 0, "clear2");
        // Reset mid-shift, then resume.
        step(0, 1, 3'b011, 8'hFF, 0, CHK_ALL, 8'hFF, 0, "load_ff");
        step(0, 1, 3'b010, 8'h00, 1, CHK_ALL, 8'hFF, 1, "shl_ff");
        step(1, 1, 3'b010, 8'h00, 1, CHK_ALL, 8'h00, 0, "rst_mid");
        step(0, 1, 3'b001, 8'h00, 1, CHK_ALL, 8'h80, 0, "resume_shr");
        step(0, 1, 3'b000, 8'h55, 1, CHK_ALL, 8'h80, 0, "mode_hold");
        step(0, 1, 3'b000, 8'h00, 0, CHK_NONE, 8'h00, 0, "drain");
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
